instr_encoder: RTL

Sequential RV32I instruction encoder and instruction-memory loader, the inverse of the decode-stage control path. It accepts decoded instruction fields (opcode, funct3, funct7, register indices, immediate) over a valid/ready handshake and packs them into 32-bit instruction words. Each packed word is written to consecutive word addresses of the instruction memory's write port. It is used by testbenches and the boot path to populate instruction memory for the pipelined core, for exactly the opcode set the main decoder supports.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/instr_encoder_if.sv | 22 ++
 rtl/instr_packer.sv | 42 ++++
 rtl/instr_encoder.sv | 100 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the instruction encoder: opcodes, instruction
// formats and encoder FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // I/S/B/J match the decoder's ImmSrc codes; R has no immediate so it sits above them.
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_R = 3'b100
  } fmt_e;

  typedef enum logic {
    ENC_LOAD = 1'b0,
    ENC_FULL = 1'b1
  } enc_state_e;

  function automatic logic op_legal(logic [6:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
         (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    return ok;
  endfunction

  function automatic fmt_e op_fmt(logic [6:0] op);
    fmt_e fmt;
    case (op)
      OP_RTYPE:  fmt = FMT_R;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_JAL:    fmt = FMT_J;
      default:   fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Decoded-field bundle handshake between a producer and the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output in_valid, op, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready
  );
endinterface

// File: rtl/instr_packer.sv
// Combinational packing of decoded RV32I fields into a 32-bit instruction word.
module instr_packer
  import riscv_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e fmt;
  logic is_shift;

  // Immediates never reach past bit 20, so the top bits are don't-care.
  logic unused_imm;
  assign unused_imm = ^imm[31:21];

  assign fmt      = op_fmt(op);
  assign is_shift = (op == OP_ITYPE) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  always_comb begin
    word  = '0;
    legal = op_legal(op);
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, op};
      FMT_I: begin
        if (is_shift) word = {funct7, imm[4:0], rs1, funct3, rd, op};
        else          word = {imm[11:0], rs1, funct3, rd, op};
      end
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accepts decoded field bundles and writes packed words
// to consecutive instruction-memory addresses with one cycle of latency.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  instr_encoder_if.slave         bus,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   err
);

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  enc_state_e    state_q, state_d;
  // Only legal bundles advance count, so it doubles as the write pointer.
  logic [CW-1:0] count_q, count_d;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          err_q;

  logic          accept;
  logic          legal;
  logic [31:0]   word;

  instr_packer u_packer (
    .op     (bus.op),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .imm    (bus.imm),
    .word   (word),
    .legal  (legal)
  );

  assign full         = (state_q == ENC_FULL);
  assign bus.in_ready = !full && !clear;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ENC_LOAD: begin
        if (clear) begin
          count_d = '0;
        end else if (accept && legal) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = ENC_FULL;
        end
      end
      ENC_FULL: begin
        if (clear) begin
          state_d = ENC_LOAD;
          count_d = '0;
        end
      end
      default: state_d = ENC_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ENC_LOAD;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mem_we_q <= accept && legal;
      err_q    <= accept && !legal;
      if (accept && legal) begin
        mem_addr_q  <= BASE_ADDR + (32'(count_q) << 2);
        mem_wdata_q <= word;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule
